// File: rtl/b2g_pkg.sv
// Shared constants, entry type and encode helpers for the binary-to-Gray pipe.
package b2g_pkg;

  localparam int B2G_WIDTH = 5;
  // Helpers work on a wide vector; callers zero-extend and truncate with casts.
  localparam int B2G_MAXW  = 32;

  typedef struct packed {
    logic [B2G_WIDTH-1:0] gray;
    logic                 step;
  } b2g_entry_t;

  // MSB passes through; every other bit is XORed with its upper neighbour.
  function automatic logic [B2G_MAXW-1:0] bin2gray(input logic [B2G_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // True when exactly one bit is set: nonzero and a power of two.
  function automatic logic popcount_is_one(input logic [B2G_MAXW-1:0] vec);
    return (vec != '0) && ((vec & (vec - B2G_MAXW'(1))) == '0);
  endfunction

endpackage

// File: rtl/b2g_fifo2.sv
// Generic 2-entry synchronous FIFO with occupancy, full and empty flags.
module b2g_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [1:0][DW-1:0] mem;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         cnt;
  logic               wr_ok, rd_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  // Raw head slot; the consumer masks it when empty.
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; a write and a read in one cycle leave cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_ok) rd_ptr <= ~rd_ptr;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/b2g_pipe.sv
// Streaming binary-to-Gray encoder with single-bit-step tagging and a 2-deep output buffer.
module b2g_pipe
  import b2g_pkg::*;
#(
  parameter int WIDTH = B2G_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_binary,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_step,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] gray;
    logic             step;
  } entry_t;

  logic             push, pop;
  logic [WIDTH-1:0] gray_in, prev_gray;
  logic             step_in;
  entry_t           wr_ent, head;
  logic [1:0]       count;
  logic             full, empty;

  // Ready depends only on occupancy, never on out_ready: no pass-through when full.
  assign in_ready  = !rst && !full;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Encode at write time; in_binary only reaches state through a push.
  assign gray_in = WIDTH'(bin2gray(B2G_MAXW'(in_binary)));
  assign step_in = popcount_is_one(B2G_MAXW'(gray_in ^ prev_gray));
  assign wr_ent  = '{gray: gray_in, step: step_in};

  b2g_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_ent),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Stale slot contents stay hidden while the buffer is empty.
  assign out_gray = empty ? '0 : head.gray;
  assign out_step = empty ? 1'b0 : head.step;

  // Remember the Gray value of the last accepted word for adjacency tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prev_gray <= '0;
    else if (push) prev_gray <= gray_in;
  end

  // Count consumed words; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_b2g_pipe.sv
// Self-checking bench: reflected-Gray table model plus directed scenarios and random traffic.
module tb_b2g_pipe;
  import b2g_pkg::*;

  localparam int W  = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_binary = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_gray;
  logic          out_step;
  logic          out_ready = 1'b0;
  logic [CW-1:0] word_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  b2g_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_binary (in_binary),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_step  (out_step),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference Gray table built by reflection, independent of the XOR formula.
  logic [W-1:0] gtab [1<<W];
  initial begin
    gtab[0] = '0;
    for (int k = 0; k < W; k++) begin
      int n;
      n = 1 << k;
      for (int i = 0; i < n; i++) gtab[n+i] = gtab[n-1-i] | W'(n);
    end
  end

  // Transaction-level model: queue of entries, last pushed Gray, pop counter.
  b2g_entry_t    mq[$];
  b2g_entry_t    m_e;
  logic [W-1:0]  mprev;
  logic [CW-1:0] mcnt;
  bit            m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mprev = '0;
      mcnt  = '0;
    end else begin
      m_push = in_valid && (mq.size() != 2);
      m_pop  = out_ready && (mq.size() != 0);
      if (m_push) begin
        m_e.gray = gtab[in_binary];
        m_e.step = ($countones(m_e.gray ^ mprev) == 1);
        mprev    = m_e.gray;
      end
      if (m_pop) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (m_push) mq.push_back(m_e);
    end
  end

  // Log of entries the DUT hands out, for directed ordering checks.
  b2g_entry_t plog[$];

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(!rst && (mq.size() != 2)));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_gray",  32'(out_gray),  32'((mq.size() != 0) ? mq[0].gray : '0));
    chk("out_step",  32'(out_step),  32'((mq.size() != 0) ? mq[0].step : 1'b0));
    chk("word_cnt",  32'(word_cnt),  32'(mcnt));
    if (!rst && out_valid && out_ready) plog.push_back('{gray: out_gray, step: out_step});
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_binary = 'x;
  endtask

  task automatic push1(input logic [W-1:0] b);
    in_valid  = 1'b1;
    in_binary = b;
    cyc();
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    plog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while rst is held.
    cyc(2);
    chk("rst_ready", 32'(in_ready),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt",   32'(word_cnt),  32'd0);

    // Basic encode with one-cycle latency.
    do_reset();
    out_ready = 1'b1;
    push1(5'b00111);
    chk("s1_lat_valid", 32'(out_valid), 32'd1);
    chk("s1_lat_gray",  32'(out_gray),  32'b00100);
    push1(5'b01110);
    push1(5'b11100);
    idle();
    cyc(3);
    chk("s1_n", 32'(plog.size()), 32'd3);
    if (plog.size() == 3) begin
      chk("s1_g0", 32'(plog[0].gray), 32'b00100);
      chk("s1_g1", 32'(plog[1].gray), 32'b01001);
      chk("s1_g2", 32'(plog[2].gray), 32'b10010);
    end
    chk("s1_cnt", 32'(word_cnt), 32'd3);

    // Full sweep including 31 -> 0 wrap.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 32; i++) push1(W'(i % 32));
    idle();
    cyc(3);
    chk("s2_n", 32'(plog.size()), 32'd33);
    for (int i = 0; i < plog.size(); i++)
      chk($sformatf("s2_step%0d", i), 32'(plog[i].step), (i == 0) ? 32'd0 : 32'd1);
    if (plog.size() == 33) chk("s2_wrap_gray", 32'(plog[32].gray), 32'd0);
    chk("s2_cnt", 32'(word_cnt), 32'd33);

    // Backpressure: third word held until space frees.
    do_reset();
    in_valid = 1'b1; in_binary = 5'd5;  cyc();
    in_binary = 5'd9;  cyc();
    in_binary = 5'd12; cyc(2);
    chk("s3_full_ready", 32'(in_ready), 32'd0);
    chk("s3_held_cnt",   32'(word_cnt), 32'd0);
    out_ready = 1'b1;
    cyc(2);
    idle();
    cyc(3);
    chk("s3_n", 32'(plog.size()), 32'd3);
    if (plog.size() == 3) begin
      chk("s3_g0", 32'(plog[0].gray), 32'b00111);
      chk("s3_g1", 32'(plog[1].gray), 32'b01101);
      chk("s3_g2", 32'(plog[2].gray), 32'b01010);
    end

    // Non-adjacent and repeated words.
    do_reset();
    out_ready = 1'b1;
    push1(5'b00000);
    push1(5'b00011);
    push1(5'b00011);
    idle();
    cyc(3);
    chk("s4_n", 32'(plog.size()), 32'd3);
    if (plog.size() == 3) begin
      chk("s4_g0", 32'(plog[0].gray), 32'b00000);
      chk("s4_s0", 32'(plog[0].step), 32'd0);
      chk("s4_g1", 32'(plog[1].gray), 32'b00010);
      chk("s4_s1", 32'(plog[1].step), 32'd1);
      chk("s4_g2", 32'(plog[2].gray), 32'b00010);
      chk("s4_s2", 32'(plog[2].step), 32'd0);
    end

    // Simultaneous push and pop at count 1.
    do_reset();
    push1(5'b00001);
    out_ready = 1'b1;
    push1(5'b00100);
    idle();
    out_ready = 1'b0;
    chk("s5_valid", 32'(out_valid), 32'd1);
    chk("s5_gray",  32'(out_gray),  32'b00110);
    chk("s5_step",  32'(out_step),  32'd0);
    chk("s5_cnt",   32'(word_cnt),  32'd1);
    cyc();
    chk("s5_still_one", 32'(in_ready), 32'd1);

    // Asynchronous reset with two entries buffered.
    do_reset();
    out_ready = 1'b1;
    push1(5'd2);
    push1(5'd3);
    out_ready = 1'b0;
    push1(5'd6);
    idle();
    chk("s6_pre_full", 32'(in_ready), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("s6_rst_valid", 32'(out_valid), 32'd0);
    chk("s6_rst_ready", 32'(in_ready),  32'd0);
    chk("s6_rst_cnt",   32'(word_cnt),  32'd0);
    chk("s6_rst_gray",  32'(out_gray),  32'd0);
    #2 rst = 1'b0;
    cyc();
    chk("s6_rel_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    push1(5'd1);
    idle();
    chk("s6_gray", 32'(out_gray), 32'b00001);
    chk("s6_step", 32'(out_step), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_binary = in_valid ? W'($urandom) : 'x;
      out_ready = ($urandom % 3) != 0;
      cyc();
    end
    idle();
    out_ready = 1'b1;
    cyc(4);
    chk("rnd_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
